// File: rtl/midi_msg_tx.sv
// Message-level MIDI transmitter: takes status plus up to two data bytes per handshake,
// applies running-status compression and serializes 8N1 frames at BAUD_DIV clocks per bit.
module midi_msg_tx #(
   parameter int unsigned BAUD_DIV       = 1600,
   parameter bit          RUNNING_STATUS = 1'b1
) (
   input  logic       reg_clk,
   input  logic       reset_reg_N,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_status,
   input  logic [7:0] msg_data1,
   input  logic [7:0] msg_data2,
   output logic       midi_txd,
   output logic       tx_busy,
   output logic       byte_done,
   output logic [7:0] running_status
);

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

   localparam logic [15:0] CntMax = 16'(BAUD_DIV - 1);

   state_e      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [23:0] bytes_q, bytes_d;
   logic [1:0]  left_q, left_d;
   logic [7:0]  rs_q, rs_d;

   logic       bit_end;
   logic [1:0] acc_len;
   logic       is_chan;
   logic       skip_status;
   logic [7:0] d1_masked;
   logic [7:0] d2_masked;

   function automatic logic [1:0] msg_len(input logic [7:0] s);
      logic [1:0] len;
      if (!s[7]) begin
         len = 2'd1;
      end else if (s < 8'hC0 || (s >= 8'hE0 && s < 8'hF0)) begin
         len = 2'd3;
      end else if (s < 8'hE0) begin
         len = 2'd2;
      end else begin
         case (s)
            8'hF2:        len = 2'd3;
            8'hF1, 8'hF3: len = 2'd2;
            default:      len = 2'd1;
         endcase
      end
      return len;
   endfunction

   assign bit_end     = (baud_cnt_q == CntMax);
   assign acc_len     = msg_len(msg_status);
   assign is_chan     = msg_status[7] && (msg_status < 8'hF0);
   assign skip_status = RUNNING_STATUS && is_chan && (msg_status == rs_q);
   assign d1_masked   = {1'b0, msg_data1[6:0]};
   assign d2_masked   = {1'b0, msg_data2[6:0]};

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      bytes_d    = bytes_q;
      left_d     = left_q;
      rs_d       = rs_q;

      if (state_q != StIdle) begin
         baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (msg_valid) begin
               state_d    = StLoad;
               baud_cnt_d = 16'd0;
               // bytes_q[7:0] is always the byte on the wire; later bytes shift down.
               if (skip_status) begin
                  bytes_d = {8'h00, d2_masked, d1_masked};
                  left_d  = acc_len - 2'd1;
               end else begin
                  bytes_d = {d2_masked, d1_masked, msg_status};
                  left_d  = acc_len;
               end
               if (is_chan) begin
                  rs_d = msg_status;
               end else if (msg_status[7:3] == 5'b11110) begin
                  rs_d = 8'h00;
               end
            end
         end
         StLoad: state_d = StStart;
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               bit_idx_d = 3'd0;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               if (left_q > 2'd1) begin
                  state_d = StStart;
                  left_d  = left_q - 2'd1;
                  bytes_d = {8'h00, bytes_q[23:8]};
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         state_q    <= StIdle;
         baud_cnt_q <= 16'd0;
         bit_idx_q  <= 3'd0;
         bytes_q    <= 24'd0;
         left_q     <= 2'd0;
         rs_q       <= 8'h00;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         bytes_q    <= bytes_d;
         left_q     <= left_d;
         rs_q       <= rs_d;
      end
   end

   always_comb begin
      midi_txd = 1'b1;
      unique case (state_q)
         StLoad, StStart: midi_txd = 1'b0;
         StData:          midi_txd = bytes_q[bit_idx_q];
         default:         midi_txd = 1'b1;
      endcase
   end

   assign msg_ready      = (state_q == StIdle);
   assign tx_busy        = (state_q != StIdle);
   assign byte_done      = (state_q == StStop) && bit_end;
   assign running_status = rs_q;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx: table of messages with expected wire bytes and running
// status, plus hand-written 1600-clock bit-width and mid-frame reset sequences.
module tb_midi_msg_tx;

   logic       reg_clk = 1'b0;
   logic       reset_reg_N;
   logic       msg_valid;
   logic [7:0] msg_status, msg_data1, msg_data2;
   int         cur_sel;

   logic       va, vb, vc;
   logic       rdy_a, rdy_b, rdy_c, txd_a, txd_b, txd_c;
   logic       busy_a, busy_b, busy_c, bd_a, bd_b, bd_c;
   logic [7:0] rs_a, rs_b, rs_c;
   logic       rdy_s, txd_s, busy_s, bd_s;
   logic [7:0] rs_s;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         sel;
      logic [7:0] st, d1, d2;
      int         n;
      logic [7:0] e0, e1, e2, rs;
   } vec_t;

   vec_t vecs[16];

   always #5 reg_clk = ~reg_clk;

   assign va = msg_valid && (cur_sel == 0);
   assign vb = msg_valid && (cur_sel == 1);
   assign vc = msg_valid && (cur_sel == 2);

   midi_msg_tx #(.BAUD_DIV(4), .RUNNING_STATUS(1'b1)) dut_a (
      .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .msg_valid(va), .msg_ready(rdy_a),
      .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
      .midi_txd(txd_a), .tx_busy(busy_a), .byte_done(bd_a), .running_status(rs_a));

   midi_msg_tx #(.BAUD_DIV(4), .RUNNING_STATUS(1'b0)) dut_b (
      .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .msg_valid(vb), .msg_ready(rdy_b),
      .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
      .midi_txd(txd_b), .tx_busy(busy_b), .byte_done(bd_b), .running_status(rs_b));

   midi_msg_tx #(.BAUD_DIV(1600), .RUNNING_STATUS(1'b1)) dut_c (
      .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .msg_valid(vc), .msg_ready(rdy_c),
      .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
      .midi_txd(txd_c), .tx_busy(busy_c), .byte_done(bd_c), .running_status(rs_c));

   always_comb begin
      rdy_s = rdy_a; txd_s = txd_a; busy_s = busy_a; bd_s = bd_a; rs_s = rs_a;
      if (cur_sel == 1) begin
         rdy_s = rdy_b; txd_s = txd_b; busy_s = busy_b; bd_s = bd_b; rs_s = rs_b;
      end else if (cur_sel == 2) begin
         rdy_s = rdy_c; txd_s = txd_c; busy_s = busy_c; bd_s = bd_c; rs_s = rs_c;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Sends one message and samples the wire every clock for the whole expected duration.
   task automatic run_msg(input vec_t v, input int d, input int id);
      logic       q[$];
      int         bd_cnt, low_err, frm_err, total, base;
      logic [7:0] exp_b[3];
      logic [7:0] got;
      logic       c, want;
      string      tag;
      tag = $sformatf("m%0d", id);
      exp_b[0] = v.e0; exp_b[1] = v.e1; exp_b[2] = v.e2;
      bd_cnt = 0; low_err = 0; frm_err = 0;
      cur_sel = v.sel;
      msg_status = v.st; msg_data1 = v.d1; msg_data2 = v.d2;
      msg_valid = 1'b1;
      #1;
      chk({tag, "_idle_pre"}, {30'd0, rdy_s, txd_s}, 32'd3);
      @(posedge reg_clk);
      #1;
      msg_valid = 1'b0;
      msg_status = ~v.st; msg_data1 = ~v.d1; msg_data2 = ~v.d2;
      chk({tag, "_rs"}, {24'd0, rs_s}, {24'd0, v.rs});
      total = v.n * 10 * d;
      for (int i = 0; i < total; i++) begin
         q.push_back(txd_s);
         if (bd_s) bd_cnt++;
         if (rdy_s || !busy_s) low_err++;
         @(posedge reg_clk);
         #1;
      end
      chk({tag, "_idle_post"}, {29'd0, rdy_s, busy_s, txd_s}, 32'd5);
      chk({tag, "_byte_done_cnt"}, bd_cnt, v.n);
      chk({tag, "_ready_low_err"}, low_err, 0);
      for (int j = 0; j < v.n; j++) begin
         got = 8'h00;
         for (int b = 0; b < 10; b++) begin
            base = (10 * j + b) * d;
            c = q[base + d / 2];
            want = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : c;
            if (c !== want) frm_err++;
            if (b >= 1 && b <= 8) got[b-1] = c;
            for (int k = 0; k < d; k++) if (q[base + k] !== c) frm_err++;
         end
         chk($sformatf("%s_byte%0d", tag, j), {24'd0, got}, {24'd0, exp_b[j]});
      end
      chk({tag, "_frame_err"}, frm_err, 0);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{0, 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 8'h90};
      vecs[1]  = '{0, 8'h90, 8'h40, 8'h50, 2, 8'h40, 8'h50, 8'h00, 8'h90};
      vecs[2]  = '{0, 8'h80, 8'h40, 8'h00, 3, 8'h80, 8'h40, 8'h00, 8'h80};
      vecs[3]  = '{0, 8'hC5, 8'h07, 8'hAA, 2, 8'hC5, 8'h07, 8'h00, 8'hC5};
      vecs[4]  = '{0, 8'hF8, 8'h11, 8'h22, 1, 8'hF8, 8'h00, 8'h00, 8'hC5};
      vecs[5]  = '{0, 8'hC5, 8'h09, 8'h33, 1, 8'h09, 8'h00, 8'h00, 8'hC5};
      vecs[6]  = '{0, 8'hF0, 8'h44, 8'h55, 1, 8'hF0, 8'h00, 8'h00, 8'h00};
      vecs[7]  = '{0, 8'hC5, 8'h01, 8'h66, 2, 8'hC5, 8'h01, 8'h00, 8'hC5};
      vecs[8]  = '{0, 8'hF2, 8'h12, 8'h34, 3, 8'hF2, 8'h12, 8'h34, 8'h00};
      vecs[9]  = '{0, 8'h3A, 8'h77, 8'h88, 1, 8'h3A, 8'h00, 8'h00, 8'h00};
      vecs[10] = '{0, 8'hE0, 8'h7F, 8'hFF, 3, 8'hE0, 8'h7F, 8'h7F, 8'hE0};
      vecs[11] = '{0, 8'hF3, 8'h05, 8'h99, 2, 8'hF3, 8'h05, 8'h00, 8'h00};
      vecs[12] = '{0, 8'hF6, 8'h00, 8'h00, 1, 8'hF6, 8'h00, 8'h00, 8'h00};
      vecs[13] = '{1, 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 8'h90};
      vecs[14] = '{1, 8'h90, 8'h40, 8'hFF, 3, 8'h90, 8'h40, 8'h7F, 8'h90};
      vecs[15] = '{1, 8'h80, 8'hFF, 8'h00, 3, 8'h80, 8'h7F, 8'h00, 8'h80};

      reset_reg_N = 1'b0;
      msg_valid   = 1'b0;
      msg_status  = 8'h00; msg_data1 = 8'h00; msg_data2 = 8'h00;
      cur_sel     = 0;
      repeat (3) @(posedge reg_clk);
      #1;
      chk("reset_state", {19'd0, txd_s, rdy_s, busy_s, bd_s, 1'b0, rs_s},
          {19'd0, 5'b11000, 8'h00});
      reset_reg_N = 1'b1;
      @(posedge reg_clk);
      #1;

      for (int i = 0; i < 16; i++) run_msg(vecs[i], 4, i);

      v = '{2, 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 8'h90};
      run_msg(v, 1600, 100);

      // Arm running status 0x90, then reset during d3 of the second (compressed) byte 0x64.
      v = '{0, 8'h90, 8'h11, 8'h22, 3, 8'h90, 8'h11, 8'h22, 8'h90};
      run_msg(v, 4, 200);
      cur_sel = 0;
      msg_status = 8'h90; msg_data1 = 8'h3C; msg_data2 = 8'h64;
      msg_valid = 1'b1;
      @(posedge reg_clk);
      #1;
      msg_valid = 1'b0;
      repeat (58) @(posedge reg_clk);
      #1;
      chk("rst_pre_txd_busy", {30'd0, txd_s, busy_s}, 32'd1);
      #2;
      reset_reg_N = 1'b0;
      #1;
      chk("rst_async", {20'd0, txd_s, rdy_s, busy_s, bd_s, rs_s}, {20'd0, 4'b1100, 8'h00});
      @(posedge reg_clk);
      #1;
      reset_reg_N = 1'b1;
      @(posedge reg_clk);
      #1;
      v = '{0, 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 8'h90};
      run_msg(v, 4, 201);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/midi_msg_tx.md
Name: midi_msg_tx

Overview:
Message-level MIDI transmitter at 31250 baud, the output-side counterpart of the MIDI receiver in the synth controller.
- Accepts one complete MIDI message per handshake (status plus up to two data bytes).
- Derives the byte count from the status byte and applies running-status compression.
- Serializes 8N1 frames on midi_txd.
- Sits between the controller's MIDI-out request logic and the physical MIDI OUT pin.

Parameters:
BAUD_DIV, 1600, reg_clk cycles per bit (50 MHz / 31250); legal range 2..65535; benches use 4.
RUNNING_STATUS, 1, 1 = omit a repeated channel status byte; 0 = always send status.

Ports:
reg_clk  input  1  system clock; all logic on rising edge.
reset_reg_N  input  1  asynchronous active-low reset.
msg_valid  input  1  message request; held until accepted.
msg_ready  output  1  high only in IDLE; transfer occurs when msg_valid & msg_ready.
msg_status  input  8  status byte, or a raw data byte if bit7 = 0.
msg_data1  input  8  first data byte (bit7 forced 0 on the wire).
msg_data2  input  8  second data byte (bit7 forced 0 on the wire).
midi_txd  output  1  serial out; idle high.
tx_busy  output  1  high whenever the FSM is not in IDLE.
byte_done  output  1  one-cycle pulse at the end of every stop bit.
running_status  output  8  current running-status register; 0 = none.

Behaviour:
Reset (asynchronous, immediate, including mid-frame; the frame is abandoned):
- midi_txd = 1, msg_ready = 1, tx_busy = 0, byte_done = 0, running_status = 0, FSM = IDLE.

Accept:
- All three input bytes are captured in the accept cycle; later input changes are ignored.
- The start bit (midi_txd = 0) begins on the next rising edge.

Length decode (len = bytes sent, before compression):
- bit7 = 0: len 1, raw byte; running_status unchanged.
- 80-BF, E0-EF: len 3.
- C0-DF: len 2.
- F2: len 3.
- F1, F3: len 2.
- F0, F4, F5, F6, F7: len 1.
- F8-FF (realtime): len 1.

Running status update:
- 80-EF sets running_status = status.
- F0-F7 clears it to 0.
- Realtime (F8-FF) and raw bytes leave it unchanged.

Compression:
- Applies when RUNNING_STATUS = 1, status is in 80-EF, and status == running_status at accept.
- The status byte is skipped; only the data bytes are sent.

Framing:
- Each byte is 10 bits: start 0, d0..d7 LSB first, stop 1.
- Each bit lasts exactly BAUD_DIV clocks, timed by a bit-rate counter cleared at accept.
- Bytes within one message are sent back-to-back with no idle gap.

FSM states:
- IDLE: on accept, go to LOAD.
- LOAD: one internal cycle; select the first byte, then go to START. Counted as part of the start bit; the start bit is still exactly BAUD_DIV clocks.
- START, then DATA (8 bits), then STOP.
- After STOP: go to the next byte if any remain, otherwise IDLE.

Handshake timing and pulses:
- msg_ready drops in the cycle after accept.
- msg_ready rises in the cycle after the final stop bit completes.
- Minimum idle high between messages is 1 clock.
- byte_done pulses once per transmitted byte, including the final byte.

Simultaneous events:
- msg_valid asserted while busy is ignored until IDLE; no queueing.
- Reset has priority over everything.

Running-status register timing:
- running_status updates in the accept cycle, so it reflects the new value throughout transmission.

Test Plan:
1. BAUD_DIV = 4, RUNNING_STATUS = 1; send 90/3C/64 -> bytes 90, 3C, 64 on the wire; 30 bit periods = 120 clocks; 3 byte_done pulses; running_status = 90.
2. Immediately send 90/40/50 -> bytes 40, 50 only (80 clocks); then send 80/40/00 -> bytes 80, 40, 00; running_status = 80.
3. Send C5/07/xx then F8 then C5/09/xx -> C5 07, then F8, then 09 (running status survives realtime); then F0 -> running_status = 0; next C5/01 -> C5 01.
4. RUNNING_STATUS = 0; repeat scenario 2 -> every message carries its status byte; data byte input 0xFF is transmitted as 7F.
5. BAUD_DIV = 1600; measure every bit width = 1600 clocks; start-bit falling edge exactly 1 clock after the accept edge; msg_ready low for exactly 30*1600 clocks on a 3-byte message.
6. Assert reset_reg_N = 0 during the data bit d3 of the second byte -> midi_txd = 1 and msg_ready = 1 asynchronously; after release, send 90/3C/64 -> full 3-byte message including status, since running_status was reset to 0.
